// File: rtl/ntt_pkg.sv
// Shared NTT datapath definitions: modulus, word widths, Barrett constant helper.
package ntt_pkg;

  localparam int NTT_W = 32;
  localparam logic [NTT_W-1:0] NTT_Q = 32'hFFF00001;

  typedef logic [NTT_W-1:0]   residue_t;
  typedef logic [2*NTT_W-1:0] product_t;

  // floor(2^(2w) / q) as a (w+1)-bit constant; w must not exceed NTT_W.
  function automatic logic [NTT_W:0] barrett_mu(input logic [NTT_W-1:0] q, input int unsigned w);
    logic [2*NTT_W:0] num;
    num = (2*NTT_W+1)'(1) << (2*w);
    return (NTT_W+1)'(num / {{(NTT_W+1){1'b0}}, q});
  endfunction

endpackage

// File: rtl/barrett_correct.sv
// Conditional double subtract: maps r < 3Q onto [0, Q). Purely combinational,
// shared with the butterfly add/sub stage.
module barrett_correct #(
  parameter int W = 32
) (
  input  logic [W+1:0] r_i,
  input  logic [W-1:0] q_i,
  output logic [W-1:0] res_o
);

  logic [W+1:0] q1_ext;
  logic [W+1:0] q2_ext;

  assign q1_ext = {2'b00, q_i};
  assign q2_ext = {1'b0, q_i, 1'b0};

  // Pick r, r-Q or r-2Q; the result fits in W bits so only the low bits are subtracted.
  always_comb begin
    res_o = r_i[W-1:0];
    if (r_i >= q2_ext) begin
      res_o = r_i[W-1:0] - {q_i[W-2:0], 1'b0};
    end else if (r_i >= q1_ext) begin
      res_o = r_i[W-1:0] - q_i;
    end
  end

endmodule

// File: rtl/barrett_reduce.sv
// Three-stage pipelined Barrett reducer: 2*wI-bit product in, residue mod Q out.
// Valid/ready on both sides; a single enable stalls the whole pipeline.
// Optional feature macro: BARRETT_RANGE_CHECK_EN (flags inputs >= Q*Q on oErr).
module barrett_reduce
  import ntt_pkg::*;
#(
  parameter int             wI = NTT_W,
  parameter int             wO = 2*wI,
  parameter logic [wI-1:0]  Q  = NTT_Q
) (
  input  logic          iClk,
  input  logic          iRst_n,
  input  logic          iValid,
  output logic          oReady,
  input  logic [wO-1:0] iX,
  output logic          oValid,
  input  logic          iReady,
  output logic [wI-1:0] oO,
  output logic          oErr
);

  localparam int QW = 2*wI+2;
  localparam logic [2*wI:0] MU_NUM = (2*wI+1)'(1) << (2*wI);
  localparam logic [wI:0]   MU     = (wI+1)'(MU_NUM / (2*wI+1)'(Q));

  logic          en;
  logic          v1_q, v2_q, v3_q;
  logic [wI:0]   q1;
  logic [QW-1:0] q2_d, q2_q;
  logic [wO-1:0] x1_q;
  logic [wI:0]   q3;
  logic [wI+1:0] x_lo;
  logic [wI+1:0] r_d, r_q;
  logic [wI-1:0] o_d, o_q;

  // Bits the quotient estimate and the truncated subtraction never look at.
  logic [wI:0]       unused_q2_lo;
  logic [wO-wI-3:0]  unused_x_hi;

  assign en     = ~v3_q | iReady;
  assign oReady = en;
  assign oValid = v3_q;
  assign oO     = o_q;

  // Stage 1: quotient pre-estimate from the top wI+1 bits of x.
  assign q1   = iX[wO-1:wI-1];
  assign q2_d = QW'(q1) * QW'(MU);

  // Stage 2: final quotient estimate and low-bit remainder (exact modulo 2^(wI+2)).
  assign q3           = q2_q[QW-1:wI+1];
  assign unused_q2_lo = q2_q[wI:0];
  assign x_lo         = x1_q[wI+1:0];
  assign unused_x_hi  = x1_q[wO-1:wI+2];
  assign r_d          = x_lo - ((wI+2)'(q3) * (wI+2)'(Q));

  // Stage 3: bring r < 3Q into [0, Q).
  barrett_correct #(
    .W (wI)
  ) u_correct (
    .r_i   (r_q),
    .q_i   (Q),
    .res_o (o_d)
  );

  // Stage valid bits; bubbles travel as v = 0 and everything holds while stalled.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else if (en) begin
      v1_q <= iValid;
      v2_q <= v1_q;
      v3_q <= v2_q;
    end
  end

  // Stage 1 data: product of the quotient pre-estimate with MU, plus x itself.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      q2_q <= '0;
      x1_q <= '0;
    end else if (en) begin
      q2_q <= q2_d;
      x1_q <= iX;
    end
  end

  // Stage 2 data: partial remainder r = x - q3*Q on wI+2 bits.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= r_d;
    end
  end

  // Stage 3 data: corrected residue, held stable until the consumer takes it.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      o_q <= '0;
    end else if (en) begin
      o_q <= o_d;
    end
  end

`ifdef BARRETT_RANGE_CHECK_EN
  localparam logic [wO-1:0] QQ = wO'(Q) * wO'(Q);

  logic e1_q, e2_q, e3_q;

  // Out-of-range flag rides alongside the data; bubbles never carry a set flag.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      e1_q <= 1'b0;
      e2_q <= 1'b0;
      e3_q <= 1'b0;
    end else if (en) begin
      e1_q <= iValid & (iX >= QQ);
      e2_q <= e1_q;
      e3_q <= e2_q;
    end
  end

  assign oErr = e3_q;
`else
  assign oErr = 1'b0;
`endif

endmodule
